// File: rtl/poly_div_35by18_if.sv
// Handshake bus for the GF(2) 35-by-18 polynomial divider: request pair in, quotient/remainder out.
interface poly_div_35by18_if;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] a;
    logic [17:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [34:0] q;
    logic [16:0] r;
    logic        err;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r, err
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r, err
    );
endinterface

// File: rtl/poly_div_35by18.sv
// Bit-serial carry-less (GF(2)) division a = q*b ^ r, one dividend bit per RUN cycle.
// Optional macro POLY_DIV_ZERO_CHECK_EN: b == 0 is flagged via err and skips the RUN phase.
module poly_div_35by18 (
    input  logic                    clk,
    input  logic                    rst,
    poly_div_35by18_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [34:0] r_a_sh;
    logic [34:0] r_q_work;
    logic [17:0] r_b;
    logic [17:0] r_rem;
    logic [4:0]  r_degb;
    logic [5:0]  r_cnt;
    logic        r_zero;

    logic        r_in_ready;
    logic        r_out_valid;
    logic [34:0] r_q;
    logic [16:0] r_r;
    logic        r_err;

    logic        w_accept;
    logic        w_b_zero;
    logic [17:0] w_rem_shift;
    logic [17:0] w_top;
    logic        w_hit;
    logic [17:0] w_rem_nxt;

    function automatic logic [4:0] f_degree(input logic [17:0] v);
        logic [4:0] d;
        d = 5'd0;
        for (int i = 0; i < 18; i++) begin
            if (v[i]) begin
                d = i[4:0];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    assign w_accept = r_in_ready & bus.in_valid;

`ifdef POLY_DIV_ZERO_CHECK_EN
    assign w_b_zero = (bus.b == 18'd0);
`else
    assign w_b_zero = 1'b0;
`endif

    // Next partial remainder: shift in the next dividend bit, reduce by b when its top term appears
    always_comb begin
        w_rem_shift = {r_rem[16:0], r_a_sh[34]};
        w_top       = 18'd1 << r_degb;
        w_hit       = |(w_rem_shift & w_top);
        if (w_hit) begin
            w_rem_nxt = w_rem_shift ^ r_b;
        end else begin
            w_rem_nxt = w_rem_shift;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_b_zero) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Division datapath: operand capture on accept, one quotient bit per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= 35'd0;
            r_q_work <= 35'd0;
            r_b      <= 18'd0;
            r_rem    <= 18'd0;
            r_degb   <= 5'd0;
            r_cnt    <= 6'd0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a_sh   <= bus.a;
                        r_b      <= bus.b;
                        r_degb   <= f_degree(bus.b);
                        r_rem    <= 18'd0;
                        r_q_work <= 35'd0;
                        r_cnt    <= 6'd34;
                        r_zero   <= w_b_zero;
                    end else begin
                        r_cnt    <= r_cnt;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= {r_a_sh[33:0], 1'b0};
                    r_rem    <= w_rem_nxt;
                    r_q_work <= {r_q_work[33:0], w_hit};
                    if (r_cnt != 6'd0) begin
                        r_cnt <= r_cnt - 6'd1;
                    end else begin
                        r_cnt <= 6'd0;
                    end
                end
                ST_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

    // Result registers: loaded once on entering DONE, held until the consumer takes them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q         <= 35'd0;
            r_r         <= 17'd0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == ST_DONE) && !r_out_valid) begin
                r_out_valid <= 1'b1;
                r_q         <= r_q_work;
                r_r         <= r_rem[16:0];
                r_err       <= r_zero;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.q         = r_q;
    assign bus.r         = r_r;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_poly_div_35by18.sv
// Randomised bench for poly_div_35by18 against a polynomial long-division reference model.
module tb_poly_div_35by18;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    poly_div_35by18_if bus ();

    poly_div_35by18 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] clmul(input logic [17:0] x, input logic [17:0] y);
        logic [34:0] p;
        p = 35'd0;
        for (int i = 0; i < 18; i++) begin
            if (y[i]) p = p ^ ({17'd0, x} << i);
        end
        return p;
    endfunction

    task automatic ref_div(input logic [34:0] a, input logic [17:0] b,
                           output logic [34:0] q, output logic [16:0] r);
        logic [34:0] rem;
        int d;
        rem = a;
        q   = 35'd0;
        d   = 0;
        for (int i = 0; i < 18; i++) if (b[i]) d = i;
        for (int i = 34; i >= d; i--) begin
            if (rem[i]) begin
                q[i - d] = 1'b1;
                rem = rem ^ ({17'd0, b} << (i - d));
            end
        end
        r = rem[16:0];
    endtask

    // Offer one pair, wait for the result (bounded), optionally consume it.
    task automatic do_op(input logic [34:0] a, input logic [17:0] b, input bit consume,
                         output logic [34:0] q, output logic [16:0] r, output logic e,
                         output int lat);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        q = bus.q;
        r = bus.r;
        e = bus.err;
        if (consume) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 35'd0 ||
            bus.r !== 17'd0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h err=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.q, bus.r, bus.err);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [34:0] av [3];
        logic [17:0] bv [3];
        logic [34:0] qe [3];
        logic [16:0] re [3];
        logic [34:0] q;
        logic [16:0] r;
        logic e;
        int lat;
        av = '{35'h5, 35'h7, 35'h7};
        bv = '{18'h3, 18'h3, 18'h1};
        qe = '{35'h3, 35'h2, 35'h7};
        re = '{17'h0, 17'h1, 17'h0};
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], 1'b1, q, r, e, lat);
            n_tests++;
            if (q !== qe[i] || r !== re[i] || e !== 1'b0 || lat !== 36) begin
                n_fail++;
                $display("FAIL vector%0d: q=%h r=%h err=%b lat=%0d, want q=%h r=%h err=0 lat=36",
                         i, q, r, e, lat, qe[i], re[i]);
            end
        end
    endtask

    task automatic test_random_div();
        logic [34:0] a, q, qe;
        logic [16:0] r, re;
        logic [17:0] b;
        logic e;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            a = {$urandom(), $urandom()};
            b = 18'($urandom());
            if (i % 3 == 0) b = b >> $urandom_range(0, 16);
            if (b == 18'd0) b = 18'd1;
            ref_div(a, b, qe, re);
            do_op(a, b, 1'b1, q, r, e, lat);
            n_tests++;
            if (q !== qe || r !== re || e !== 1'b0 || lat !== 36) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_div a=%h b=%h: q=%h r=%h err=%b lat=%0d, want q=%h r=%h lat=36",
                             a, b, q, r, e, lat, qe, re);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [17:0] x, y;
        logic [34:0] q;
        logic [16:0] r;
        logic e;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = 18'($urandom());
            y = 18'($urandom());
            if (y == 18'd0) y = 18'h2_0001;
            do_op(clmul(x, y), y, 1'b1, q, r, e, lat);
            n_tests++;
            if (q !== {17'd0, x} || r !== 17'd0 || e !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL round_trip x=%h y=%h: q=%h r=%h err=%b, want q=%h r=0",
                             x, y, q, r, e, x);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] a, q, qe;
        logic [16:0] r, re;
        logic [17:0] b;
        logic e;
        int lat;
        a = 35'h5_A5A5_1234;
        b = 18'h2_C0F3;
        ref_div(a, b, qe, re);
        do_op(a, b, 1'b0, q, r, e, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.q !== qe ||
                bus.r !== re || bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: vld=%b rdy=%b q=%h r=%h err=%b, want 1 0 %h %h 0",
                         i, bus.out_valid, bus.in_ready, bus.q, bus.r, bus.err, qe, re);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_ignore_inputs();
        logic [34:0] a, qe;
        logic [16:0] re;
        logic [17:0] b;
        int lat;
        a = 35'h6_1357_9BDF;
        b = 18'h0_0B5D;
        ref_div(a, b, qe, re);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            bus.a = {$urandom(), $urandom()};
            bus.b = 18'($urandom());
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.q !== qe || bus.r !== re || lat !== 36) begin
            n_fail++;
            $display("FAIL ignore_inputs: q=%h r=%h lat=%0d, want q=%h r=%h lat=36",
                     bus.q, bus.r, lat, qe, re);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [34:0] q;
        logic [16:0] r;
        logic e;
        int lat;
        int seen;
        bus.a = 35'h7_FFFF_FFFF;
        bus.b = 18'h3_FFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 35'd0 ||
            bus.r !== 17'd0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b q=%h r=%h err=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.q, bus.r, bus.err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abandon: out_valid seen %0d cycles, want 0", seen);
        end
        do_op(35'h5, 18'h3, 1'b1, q, r, e, lat);
        n_tests++;
        if (q !== 35'h3 || r !== 17'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: q=%h r=%h err=%b, want q=3 r=0 err=0", q, r, e);
        end
    endtask

    task automatic test_zero_div();
        logic [34:0] q;
        logic [16:0] r;
        logic e;
        int lat;
        do_op(35'h1_2345_6789, 18'd0, 1'b1, q, r, e, lat);
        n_tests++;
`ifdef POLY_DIV_ZERO_CHECK_EN
        if (lat !== 1 || e !== 1'b1 || q !== 35'd0 || r !== 17'd0) begin
            n_fail++;
            $display("FAIL zero_div: lat=%0d err=%b q=%h r=%h, want lat=1 err=1 q=0 r=0",
                     lat, e, q, r);
        end
`else
        if (lat !== 36 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_div: lat=%0d err=%b, want lat=36 err=0", lat, e);
        end
`endif
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_tests = 0;
        n_fail = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 35'd0;
        bus.b = 18'd0;
        test_reset();
        test_vectors();
        test_random_div();
        test_round_trip();
        test_backpressure();
        test_ignore_inputs();
        test_reset_mid_run();
        test_zero_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
